// File: rtl/pc_stack_unit.sv
// Program counter with an internal hardware return stack for call/return linkage.
// Next PC is chosen from PC+1, an absolute jump, a relative branch, or the stack top.
module pc_stack_unit #(
  parameter int unsigned PC_WIDTH     = 12,
  parameter int unsigned STACK_DEPTH  = 8,
  parameter int unsigned PTR_WIDTH    = 4,
  parameter int unsigned OFFSET_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enablePC,
  input  logic [1:0]              selectAdress,
  input  logic [PC_WIDTH-1:0]     jumpTarget,
  input  logic [OFFSET_WIDTH-1:0] branchOffset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    RET,
  output logic [PC_WIDTH-1:0]     pc,
  output logic [PC_WIDTH-1:0]     stackTop,
  output logic                    stackEmpty,
  output logic                    stackFull,
  output logic [PTR_WIDTH-1:0]    callDepth,
  output logic                    stackOverflow,
  output logic                    stackUnderflow
);

  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_WIDTH-1:0]  stackMem [STACK_DEPTH];
  logic [PTR_WIDTH-1:0] sp;
  logic [PTR_WIDTH-1:0] spNext;
  logic [PC_WIDTH-1:0]  pcNext;
  logic [PC_WIDTH-1:0]  inc;
  logic [PC_WIDTH-1:0]  offsetExt;
  logic [1:0]           src;
  logic                 ovfNext;
  logic                 udfNext;
  logic                 wrEn;
  logic [IDX_W-1:0]     wrIdx;
  logic [IDX_W-1:0]     topIdx;

  assign stackEmpty = (sp == '0);
  assign stackFull  = (sp == PTR_WIDTH'(STACK_DEPTH));
  assign callDepth  = sp;
  assign topIdx     = IDX_W'(sp - PTR_WIDTH'(1));
  assign stackTop   = stackEmpty ? '0 : stackMem[topIdx];
  assign offsetExt  = {{(PC_WIDTH-OFFSET_WIDTH){branchOffset[OFFSET_WIDTH-1]}}, branchOffset};

  // Next-PC selection and stack pointer / flag update
  always_comb begin
    inc     = pc + PC_WIDTH'(1);
    src     = RET ? 2'b11 : selectAdress;
    pcNext  = pc;
    spNext  = sp;
    ovfNext = stackOverflow;
    udfNext = stackUnderflow;
    wrEn    = 1'b0;
    wrIdx   = IDX_W'(sp);
    if (enablePC) begin
      case (src)
        2'b00:   pcNext = inc;
        2'b01:   pcNext = jumpTarget;
        2'b10:   pcNext = inc + offsetExt;
        default: begin
          // Returning from an empty stack keeps the current PC
          if (stackEmpty) udfNext = 1'b1;
          else            pcNext  = stackTop;
        end
      endcase
      if (push && pop && !stackEmpty) begin
        wrEn  = 1'b1;
        wrIdx = topIdx;
      end else if (push) begin
        if (stackFull) begin
          ovfNext = 1'b1;
        end else begin
          wrEn   = 1'b1;
          spNext = sp + PTR_WIDTH'(1);
        end
      end else if (pop) begin
        if (stackEmpty) udfNext = 1'b1;
        else            spNext  = sp - PTR_WIDTH'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= '0;
      sp             <= '0;
      stackOverflow  <= 1'b0;
      stackUnderflow <= 1'b0;
    end else begin
      pc             <= pcNext;
      sp             <= spNext;
      stackOverflow  <= ovfNext;
      stackUnderflow <= udfNext;
    end
  end

  // Stack storage needs no reset: entries above sp are never observed
  always_ff @(posedge clk) begin
    if (!rst && wrEn) stackMem[wrIdx] <= inc;
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed self-checking bench for pc_stack_unit.
module tb_pc_stack_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        enablePC;
  logic [1:0]  selectAdress;
  logic [11:0] jumpTarget;
  logic [7:0]  branchOffset;
  logic        push;
  logic        pop;
  logic        RET;
  logic [11:0] pc;
  logic [11:0] stackTop;
  logic        stackEmpty;
  logic        stackFull;
  logic [3:0]  callDepth;
  logic        stackOverflow;
  logic        stackUnderflow;

  int nChecks = 0;
  int nFails  = 0;

  pc_stack_unit dut (
    .clk(clk), .rst(rst), .enablePC(enablePC), .selectAdress(selectAdress),
    .jumpTarget(jumpTarget), .branchOffset(branchOffset), .push(push), .pop(pop),
    .RET(RET), .pc(pc), .stackTop(stackTop), .stackEmpty(stackEmpty),
    .stackFull(stackFull), .callDepth(callDepth), .stackOverflow(stackOverflow),
    .stackUnderflow(stackUnderflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic e, input logic [1:0] s, input logic [11:0] jt,
                       input logic [7:0] bo, input logic pu, input logic po, input logic rt);
    enablePC = e; selectAdress = s; jumpTarget = jt; branchOffset = bo;
    push = pu; pop = po; RET = rt;
  endtask

  task automatic doReset;
    rst = 1'b1; setIn(1'b0, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic jumpTo(input logic [11:0] t);
    setIn(1'b1, 2'b01, t, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset;
    doReset();
    nChecks++; if (pc !== 12'h000) begin nFails++; $display("FAIL reset_pc got=%h exp=000", pc); end
    nChecks++; if (callDepth !== 4'd0) begin nFails++; $display("FAIL reset_depth got=%0d exp=0", callDepth); end
    nChecks++; if (stackEmpty !== 1'b1 || stackFull !== 1'b0) begin nFails++; $display("FAIL reset_empty_full got=%b%b exp=10", stackEmpty, stackFull); end
    nChecks++; if (stackTop !== 12'h000) begin nFails++; $display("FAIL reset_top got=%h exp=000", stackTop); end
    nChecks++; if (stackOverflow !== 1'b0 || stackUnderflow !== 1'b0) begin nFails++; $display("FAIL reset_flags got=%b%b exp=00", stackOverflow, stackUnderflow); end
  endtask

  task automatic test_sequential;
    doReset();
    setIn(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      nChecks++; if (pc !== 12'(i)) begin nFails++; $display("FAIL seq_pc got=%h exp=%h", pc, 12'(i)); end
    end
    nChecks++; if (stackEmpty !== 1'b1 || callDepth !== 4'd0) begin nFails++; $display("FAIL seq_stack got=%b/%0d exp=1/0", stackEmpty, callDepth); end
  endtask

  task automatic test_call_return;
    doReset();
    jumpTo(12'd10);
    setIn(1'b1, 2'b01, 12'h200, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    nChecks++; if (pc !== 12'h200) begin nFails++; $display("FAIL call_pc got=%h exp=200", pc); end
    nChecks++; if (stackTop !== 12'd11) begin nFails++; $display("FAIL call_top got=%h exp=00b", stackTop); end
    nChecks++; if (callDepth !== 4'd1) begin nFails++; $display("FAIL call_depth got=%0d exp=1", callDepth); end
    setIn(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    nChecks++; if (pc !== 12'd11) begin nFails++; $display("FAIL ret_pc got=%h exp=00b", pc); end
    nChecks++; if (stackEmpty !== 1'b1) begin nFails++; $display("FAIL ret_empty got=%b exp=1", stackEmpty); end
  endtask

  task automatic test_nested;
    logic [11:0] exp;
    doReset();
    for (int i = 1; i <= 8; i++) begin
      jumpTo(12'(i * 16));
      setIn(1'b1, 2'b01, 12'(12'h100 + i), 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
      nChecks++; if (callDepth !== 4'(i)) begin nFails++; $display("FAIL nest_depth got=%0d exp=%0d", callDepth, i); end
    end
    nChecks++; if (stackFull !== 1'b1 || stackEmpty !== 1'b0) begin nFails++; $display("FAIL nest_full got=%b%b exp=10", stackFull, stackEmpty); end
    nChecks++; if (stackOverflow !== 1'b0) begin nFails++; $display("FAIL nest_noovf got=%b exp=0", stackOverflow); end
    jumpTo(12'h090);
    setIn(1'b1, 2'b01, 12'h300, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    nChecks++; if (stackOverflow !== 1'b1) begin nFails++; $display("FAIL ovf_flag got=%b exp=1", stackOverflow); end
    nChecks++; if (callDepth !== 4'd8) begin nFails++; $display("FAIL ovf_depth got=%0d exp=8", callDepth); end
    nChecks++; if (pc !== 12'h300) begin nFails++; $display("FAIL ovf_pc got=%h exp=300", pc); end
    nChecks++; if (stackTop !== 12'h081) begin nFails++; $display("FAIL ovf_top got=%h exp=081", stackTop); end
    for (int k = 8; k >= 1; k--) begin
      setIn(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1);
      tick();
      exp = 12'(k * 16 + 1);
      nChecks++; if (pc !== exp) begin nFails++; $display("FAIL lifo_pc got=%h exp=%h", pc, exp); end
    end
    nChecks++; if (stackEmpty !== 1'b1 || stackOverflow !== 1'b1) begin nFails++; $display("FAIL lifo_end got=%b%b exp=11", stackEmpty, stackOverflow); end
  endtask

  task automatic test_underflow;
    doReset();
    jumpTo(12'h055);
    setIn(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    nChecks++; if (pc !== 12'h055) begin nFails++; $display("FAIL udf_pc got=%h exp=055", pc); end
    nChecks++; if (stackUnderflow !== 1'b1) begin nFails++; $display("FAIL udf_flag got=%b exp=1", stackUnderflow); end
    nChecks++; if (callDepth !== 4'd0) begin nFails++; $display("FAIL udf_depth got=%0d exp=0", callDepth); end
    setIn(1'b1, 2'b11, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    nChecks++; if (pc !== 12'h055) begin nFails++; $display("FAIL udf_sel11_pc got=%h exp=055", pc); end
    setIn(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    nChecks++; if (pc !== 12'h057 || stackUnderflow !== 1'b1) begin nFails++; $display("FAIL udf_sticky got=%h/%b exp=057/1", pc, stackUnderflow); end
  endtask

  task automatic test_branch;
    doReset();
    jumpTo(12'h00F);
    setIn(1'b1, 2'b10, 12'h000, 8'hF0, 1'b0, 1'b0, 1'b0);
    tick();
    nChecks++; if (pc !== 12'h000) begin nFails++; $display("FAIL br_neg got=%h exp=000", pc); end
    jumpTo(12'hFFF);
    setIn(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    nChecks++; if (pc !== 12'h000) begin nFails++; $display("FAIL inc_wrap got=%h exp=000", pc); end
    setIn(1'b1, 2'b10, 12'h000, 8'hFE, 1'b0, 1'b0, 1'b0);
    tick();
    nChecks++; if (pc !== 12'hFFF) begin nFails++; $display("FAIL br_wrap got=%h exp=fff", pc); end
    setIn(1'b1, 2'b10, 12'h000, 8'h05, 1'b0, 1'b0, 1'b0);
    tick();
    nChecks++; if (pc !== 12'h005) begin nFails++; $display("FAIL br_pos got=%h exp=005", pc); end
  endtask

  task automatic test_hold_and_replace;
    // Continues from pc=0x005 with an empty stack
    setIn(1'b1, 2'b00, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    nChecks++; if (pc !== 12'h006 || stackTop !== 12'h006 || callDepth !== 4'd1) begin nFails++; $display("FAIL push_inc got=%h/%h/%0d exp=006/006/1", pc, stackTop, callDepth); end
    setIn(1'b0, 2'b01, 12'h3AB, 8'h00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    nChecks++; if (pc !== 12'h006 || callDepth !== 4'd1 || stackTop !== 12'h006) begin nFails++; $display("FAIL hold got=%h/%0d/%h exp=006/1/006", pc, callDepth, stackTop); end
    nChecks++; if (stackOverflow !== 1'b0 || stackUnderflow !== 1'b0) begin nFails++; $display("FAIL hold_flags got=%b%b exp=00", stackOverflow, stackUnderflow); end
    setIn(1'b1, 2'b00, 12'h000, 8'h00, 1'b1, 1'b1, 1'b0);
    tick();
    nChecks++; if (pc !== 12'h007 || stackTop !== 12'h007 || callDepth !== 4'd1) begin nFails++; $display("FAIL replace got=%h/%h/%0d exp=007/007/1", pc, stackTop, callDepth); end
    jumpTo(12'h123);
    setIn(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    nChecks++; if (pc !== 12'h007 || callDepth !== 4'd1) begin nFails++; $display("FAIL ret_nopop got=%h/%0d exp=007/1", pc, callDepth); end
  endtask

  task automatic test_reset_mid;
    doReset();
    setIn(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    nChecks++; if (stackUnderflow !== 1'b1 || pc !== 12'h001) begin nFails++; $display("FAIL pop_empty got=%b/%h exp=1/001", stackUnderflow, pc); end
    setIn(1'b1, 2'b00, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    nChecks++; if (callDepth !== 4'd2) begin nFails++; $display("FAIL mid_depth got=%0d exp=2", callDepth); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nChecks++; if (pc !== 12'h000 || callDepth !== 4'd0 || stackEmpty !== 1'b1) begin nFails++; $display("FAIL mid_rst got=%h/%0d/%b exp=000/0/1", pc, callDepth, stackEmpty); end
    nChecks++; if (stackOverflow !== 1'b0 || stackUnderflow !== 1'b0) begin nFails++; $display("FAIL mid_rst_flags got=%b%b exp=00", stackOverflow, stackUnderflow); end
  endtask

  initial begin
    rst = 1'b1;
    setIn(1'b0, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_sequential();
    test_call_return();
    test_nested();
    test_underflow();
    test_branch();
    test_hold_and_replace();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Program-counter and hardware return-stack stage sitting directly downstream of the instruction controller. It consumes the controller's enablePC, selectAdress, push, pop and RET strobes, plus address fields decoded from the 19-bit instruction word. It produces the registered PC that addresses instruction memory for the next fetch. Call and return targets are held in an internal LIFO, so no data-memory traffic is needed for subroutine linkage.

Parameters:
PC_WIDTH, 12, width of PC and of every stack entry (4096-word instruction space)
STACK_DEPTH, 8, number of return-address entries
PTR_WIDTH, 4, stack-pointer width; must satisfy 2^PTR_WIDTH > STACK_DEPTH so a full stack is representable
OFFSET_WIDTH, 8, width of the signed relative-branch offset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
enablePC  in  1  qualifies PC update and all stack operations for this cycle
selectAdress  in  2  next-PC source: 00 PC+1, 01 jumpTarget, 10 PC+1+sext(branchOffset), 11 stack top
jumpTarget  in  PC_WIDTH  absolute target, instruction bits [11:0]
branchOffset  in  OFFSET_WIDTH  signed relative offset, instruction bits [7:0]
push  in  1  call: push PC+1 onto stack
pop  in  1  discard top entry (decrement pointer)
RET  in  1  return: forces next-PC source to stack top regardless of selectAdress
pc  out  PC_WIDTH  current program counter (registered)
stackTop  out  PC_WIDTH  entry at sp-1; 0 when empty (combinational)
stackEmpty  out  1  sp == 0
stackFull  out  1  sp == STACK_DEPTH
callDepth  out  PTR_WIDTH  current sp
stackOverflow  out  1  sticky error flag
stackUnderflow  out  1  sticky error flag

Behaviour:
- Reset (rst=1 at a rising edge, dominates all other inputs):
  - pc=0, sp=0, stackOverflow=0, stackUnderflow=0.
  - Stack contents are don't-care after reset; stackTop reads 0 because the stack is empty.
  - Reset asserted mid-call-sequence discards all pending returns.
- enablePC=0: pc, sp, stack contents and flags all hold. push, pop and RET are ignored.
- enablePC=1, next PC (one-cycle latency; the new pc is visible after the edge):
  - src = 11 if RET=1, otherwise selectAdress.
  - 00: pc+1.
  - 01: jumpTarget.
  - 10: pc+1+sign-extended branchOffset.
  - 11: stackTop.
  - All arithmetic is modulo 2^PC_WIDTH: 4095+1 wraps to 0; a negative offset below 0 wraps.
- Stack operations (only when enablePC=1), with inc=pc+1 sampled from the pre-edge pc:
  - push only, not full: stack[sp]<=inc; sp<=sp+1.
  - push only, full: no write, sp holds, stackOverflow<=1. The PC still updates per src.
  - pop only, not empty: sp<=sp-1.
  - pop only, empty: sp holds, stackUnderflow<=1.
  - push and pop together, not empty: stack[sp-1]<=inc (top replaced); sp unchanged.
  - push and pop together, empty: behaves as push only.
- Return from an empty stack: src=11 (including via RET) with stackEmpty=1 sets stackUnderflow<=1 and pc holds its current value rather than loading 0.
- RET normally arrives together with pop. RET without pop reads the top entry without discarding it.
- Flags: stackOverflow and stackUnderflow are sticky and cleared only by rst.
- stackFull and stackEmpty are combinational from sp and are never asserted simultaneously.

Test Plan:
- Reset then enablePC=1, selectAdress=00 for 5 cycles -> pc sequence 0,1,2,3,4,5; stackEmpty=1; callDepth=0.
- pc=10, selectAdress=01, jumpTarget=0x200, push=1 -> next pc=0x200, stackTop=11, callDepth=1. Then RET=1, pop=1 -> pc=11, stackEmpty=1.
- Nested calls: 8 pushes from pc=0x010,0x020,…,0x080 -> stackFull=1. A 9th push -> stackOverflow=1, callDepth stays 8, jump still taken. 8 returns -> pc=0x081,0x071,…,0x011 in LIFO order.
- Return with empty stack at pc=0x055 -> pc stays 0x055, stackUnderflow=1 and it persists until rst.
- Branch arithmetic:
  - pc=0x00F, branchOffset=0xF0 (-16), selectAdress=10 -> pc=0x000.
  - pc=0xFFF, selectAdress=00 -> pc=0x000.
  - pc=0x000, branchOffset=0xFE -> pc=0xFFF.
- enablePC=0 with push=1, RET=1 held for 3 cycles -> pc, callDepth and flags all unchanged.
- Depth 2, then rst=1 with push=1 asserted -> pc=0, callDepth=0, flags clear.
